alu_seq_ctrl: RTL and testbench



---
 rtl/alu_seq_ctrl_if.sv | 35 +++
 rtl/alu_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - request, ALU drive/return, response and flag signals of alu_seq_ctrl
interface alu_seq_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_cout;
  logic       alu_error;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic [3:0] rsp_flags;
  logic [3:0] sticky_flags;
  logic       sticky_clr;
  logic       busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_result, alu_cout, alu_error,
           rsp_ready, sticky_clr,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_flags,
           sticky_flags, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_result, alu_cout, alu_error,
           rsp_ready, sticky_clr,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_flags,
           sticky_flags, busy
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - IDLE/EXEC/RESP sequencer for a 4-bit ALU with captured and sticky flags
// Optional macro ALU_SEQ_BACK2BACK_EN: a new request may be accepted on the response-accept edge.
module alu_seq_ctrl #(
  parameter int LAT_SHORT = 1,
  parameter int LAT_LONG  = 4
) (
  input  logic          clk,
  input  logic          reset,
  alu_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_S = 4'(LAT_SHORT);
  localparam logic [3:0] LAT_L = 4'(LAT_LONG);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [3:0] r_alu_a;
  logic [3:0] r_alu_b;
  logic [2:0] r_alu_op;
  logic [3:0] r_rsp_result;
  logic [3:0] r_rsp_flags;
  logic [3:0] r_sticky;

  logic       w_req_ready;
  logic       w_rsp_valid;
  logic       w_busy;
  logic       w_accept;
  logic       w_capture;
  logic       w_ovf;
  logic [3:0] w_lat;
  logic [3:0] w_new_flags;

  assign w_accept  = bus.req_valid & w_req_ready;
  assign w_lat     = bus.req_op[2] ? LAT_L : LAT_S;
  // Counter runs LAT..0 and the capture happens in the zero cycle, giving LAT+1 clocks to rsp_valid.
  assign w_capture = (r_state == S_EXEC) && (r_cnt == 4'd0);

  always_comb begin
    w_ovf = 1'b0;
    case (r_alu_op)
      3'b000:  w_ovf = (r_alu_a[3] == r_alu_b[3]) && (bus.alu_result[3] != r_alu_a[3]);
      3'b001:  w_ovf = (r_alu_a[3] != r_alu_b[3]) && (bus.alu_result[3] != r_alu_a[3]);
      default: w_ovf = 1'b0;
    endcase
  end

  assign w_new_flags = {bus.alu_error, bus.alu_cout, (bus.alu_result == 4'd0), w_ovf};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_EXEC;
      S_EXEC: if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP: begin
        if (w_accept) begin
          w_next = S_EXEC;
        end else if (bus.rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        w_busy      = 1'b0;
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
`ifdef ALU_SEQ_BACK2BACK_EN
        w_req_ready = bus.rsp_ready;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= 4'd0;
      r_alu_a      <= 4'd0;
      r_alu_b      <= 4'd0;
      r_alu_op     <= 3'd0;
      r_rsp_result <= 4'd0;
      r_rsp_flags  <= 4'd0;
      r_sticky     <= 4'd0;
    end else begin
      if (w_accept) begin
        r_alu_a  <= bus.req_a;
        r_alu_b  <= bus.req_b;
        r_alu_op <= bus.req_op;
        r_cnt    <= w_lat;
      end else if ((r_state == S_EXEC) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        r_rsp_result <= bus.alu_result;
        r_rsp_flags  <= w_new_flags;
      end
      // A clear coinciding with a capture still keeps the freshly captured flags.
      if (w_capture) begin
        r_sticky <= (bus.sticky_clr ? 4'd0 : r_sticky) | w_new_flags;
      end else if (bus.sticky_clr) begin
        r_sticky <= 4'd0;
      end
    end
  end

  assign bus.req_ready    = w_req_ready;
  assign bus.rsp_valid    = w_rsp_valid;
  assign bus.busy         = w_busy;
  assign bus.alu_a        = r_alu_a;
  assign bus.alu_b        = r_alu_b;
  assign bus.alu_op       = r_alu_op;
  assign bus.rsp_result   = r_rsp_result;
  assign bus.rsp_flags    = r_rsp_flags;
  assign bus.sticky_flags = r_sticky;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl: vector table, corner sequences, random vs model
module tb_alu_seq_ctrl;
  localparam int LS = 1;
  localparam int LL = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_ctrl_if bus();
  alu_seq_ctrl #(.LAT_SHORT(LS), .LAT_LONG(LL)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_sticky = 4'd0;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic [3:0] flags;
    int         lat;
  } vec_t;

  // Bench ALU: {err, cout, result}
  function automatic logic [5:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] w;
    logic [5:0] r;
    r = '0;
    case (op)
      3'd0: begin w = {4'd0, a} + {4'd0, b}; r = {1'b0, w[4], w[3:0]}; end
      3'd1: r = {1'b0, (a >= b), a - b};
      3'd2: r = {2'b0, a & b};
      3'd3: r = {2'b0, a | b};
      3'd4: begin w = {4'd0, a} * {4'd0, b}; r = {1'b0, (w[7:4] != 4'd0), w[3:0]}; end
      3'd5: r = (b == 4'd0) ? 6'b100000 : {2'b0, a / b};
      3'd6: r = {2'b0, a ^ b};
      default: r = (b == 4'd0) ? 6'b100000 : {2'b0, a % b};
    endcase
    return r;
  endfunction

  // Reference: {flags, result}, overflow from signed arithmetic range
  function automatic logic [7:0] ref_model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [5:0] r;
    int sa, sb, s;
    logic ovf;
    r   = alu_fn(op, a, b);
    sa  = a[3] ? int'(a) - 16 : int'(a);
    sb  = b[3] ? int'(b) - 16 : int'(b);
    ovf = 1'b0;
    if (op == 3'd0) begin s = sa + sb; ovf = (s > 7) || (s < -8); end
    if (op == 3'd1) begin s = sa - sb; ovf = (s > 7) || (s < -8); end
    return {r[5], r[4], (r[3:0] == 4'd0), ovf, r[3:0]};
  endfunction

  always_comb begin
    {bus.alu_error, bus.alu_cout, bus.alu_result} = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic accept_rsp();
    @(negedge clk); bus.rsp_ready = 1'b1;
    @(posedge clk); #1; bus.rsp_ready = 1'b0;
  endtask

  task automatic run_txn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input int stall,
                         input logic [3:0] e_res, input logic [3:0] e_flags, input int e_lat, input string tag);
    int g;
    int lat;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
    g = 0;
    while (!bus.req_ready && g < 20) begin @(negedge clk); g++; end
    check({tag, " accept_timeout"}, 32'(g >= 20), 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check({tag, " alu_a"}, bus.alu_a, a);
    check({tag, " alu_op"}, bus.alu_op, op);
    wait_rsp(lat);
    check({tag, " latency"}, lat, e_lat);
    exp_sticky = exp_sticky | e_flags;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, " stall_valid"}, bus.rsp_valid, 1);
      check({tag, " stall_result"}, bus.rsp_result, e_res);
    end
    check({tag, " result"}, bus.rsp_result, e_res);
    check({tag, " flags"}, bus.rsp_flags, e_flags);
    check({tag, " sticky"}, bus.sticky_flags, exp_sticky);
    accept_rsp();
    check({tag, " valid_drop"}, bus.rsp_valid, 0);
  endtask

  vec_t vecs[$];

  initial begin
    int lat;
    logic seen;
    logic [7:0] e;
    logic [2:0] op;
    logic [3:0] a, b;

    vecs.push_back('{3'b101, 4'd3,  4'd0,  4'd0,  4'b1010, LL + 1});
    vecs.push_back('{3'b000, 4'd7,  4'd1,  4'd8,  4'b0001, LS + 1});
    vecs.push_back('{3'b001, 4'd5,  4'd5,  4'd0,  4'b0110, LS + 1});
    vecs.push_back('{3'b001, 4'd8,  4'd1,  4'd7,  4'b0101, LS + 1});
    vecs.push_back('{3'b000, 4'd15, 4'd2,  4'd1,  4'b0100, LS + 1});
    vecs.push_back('{3'b100, 4'd3,  4'd5,  4'd15, 4'b0000, LL + 1});
    vecs.push_back('{3'b010, 4'd12, 4'd10, 4'd8,  4'b0000, LS + 1});
    vecs.push_back('{3'b110, 4'd9,  4'd9,  4'd0,  4'b0010, LL + 1});

    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.rsp_ready = 1'b0; bus.sticky_clr = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", bus.req_ready, 1);
    check("reset rsp_valid", bus.rsp_valid, 0);
    check("reset busy", bus.busy, 0);
    check("reset alu", {bus.alu_a, bus.alu_b, bus.alu_op}, 0);
    check("reset rsp", {bus.rsp_result, bus.rsp_flags}, 0);
    check("reset sticky", bus.sticky_flags, 0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_txn(vecs[i].op, vecs[i].a, vecs[i].b, 0, vecs[i].res, vecs[i].flags, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // sticky_clr on the capture edge of add 15+2 (flags 0100)
    check("pre_clr sticky", 32'(bus.sticky_flags != 4'd0), 1);
    @(negedge clk); bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_a = 4'd15; bus.req_b = 4'd2;
    @(posedge clk); #1; bus.req_valid = 1'b0;
    @(posedge clk); #1; bus.sticky_clr = 1'b1;
    @(posedge clk); #1; bus.sticky_clr = 1'b0;
    check("clr_capture valid", bus.rsp_valid, 1);
    check("clr_capture sticky", bus.sticky_flags, 4'b0100);
    exp_sticky = 4'b0100;
    accept_rsp();

    @(negedge clk); bus.sticky_clr = 1'b1;
    @(posedge clk); #1; bus.sticky_clr = 1'b0;
    check("idle_clr sticky", bus.sticky_flags, 0);
    check("idle keeps rsp_result", bus.rsp_result, 4'd1);
    exp_sticky = 4'd0;

    // backpressure with a concurrent request, then back-to-back / IDLE bubble
    @(negedge clk); bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_a = 4'd7; bus.req_b = 4'd1;
    @(posedge clk); #1; bus.req_valid = 1'b0;
    wait_rsp(lat);
    check("bp latency", lat, LS + 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); bus.req_valid = 1'b1; bus.req_op = 3'd1; bus.req_a = 4'd5; bus.req_b = 4'd5;
      @(posedge clk); #1;
      check("bp valid", bus.rsp_valid, 1);
      check("bp result", bus.rsp_result, 4'd8);
      check("bp flags", bus.rsp_flags, 4'b0001);
      check("bp req_ready", bus.req_ready, 0);
      check("bp alu_a held", bus.alu_a, 4'd7);
    end
    @(negedge clk); bus.rsp_ready = 1'b1;
    @(posedge clk); #1; bus.rsp_ready = 1'b0;
`ifdef ALU_SEQ_BACK2BACK_EN
    bus.req_valid = 1'b0;
    check("b2b busy", bus.busy, 1);
    check("b2b alu_a", bus.alu_a, 4'd5);
`else
    check("bubble busy", bus.busy, 0);
    check("bubble req_ready", bus.req_ready, 1);
    check("bubble alu_a", bus.alu_a, 4'd7);
    @(posedge clk); #1; bus.req_valid = 1'b0;
    check("after_bubble alu_a", bus.alu_a, 4'd5);
    check("after_bubble busy", bus.busy, 1);
`endif
    wait_rsp(lat);
    check("second valid", bus.rsp_valid, 1);
    check("second flags", bus.rsp_flags, 4'b0110);
    exp_sticky = 4'b0111;
    check("second sticky", bus.sticky_flags, exp_sticky);
    accept_rsp();

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      e  = ref_model(op, a, b);
      run_txn(op, a, b, $urandom_range(0, 2), e[3:0], e[7:4], (op[2] ? LL : LS) + 1, $sformatf("rand%0d", i));
    end

    // reset in the middle of a long op
    @(negedge clk); bus.req_valid = 1'b1; bus.req_op = 3'd4; bus.req_a = 4'd9; bus.req_b = 4'd3;
    @(posedge clk); #1; bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("mid busy", bus.busy, 1);
    reset = 1'b1; #1;
    check("rst_exec busy", bus.busy, 0);
    check("rst_exec req_ready", bus.req_ready, 1);
    check("rst_exec alu_a", bus.alu_a, 0);
    check("rst_exec sticky", bus.sticky_flags, 0);
    @(negedge clk); reset = 1'b0;
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (bus.rsp_valid) seen = 1'b1; end
    check("rst_exec no_rsp", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
